pgm_ddram_arbiter: RTL and testbench

PGM_DDRAM_ARBITER -- requirements
Module: pgm_ddram_arbiter

---
 rtl/pgm_pkg.sv | 38 +++
 rtl/pgm_arb_prio.sv | 24 ++
 rtl/pgm_ddram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_pgm_ddram_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pgm_pkg.sv
// Shared types and constants for the program-ROM DDRAM read arbiter.
// Requester bit positions match the {aud, vid, cpu} request vector.
package pgm_pkg;

  localparam int DDRAM_AW = 29;
  localparam int DDRAM_DW = 64;

  localparam int REQ_CPU = 0;
  localparam int REQ_VID = 1;
  localparam int REQ_AUD = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_VID  = 2'd2,
    GNT_AUD  = 2'd3
  } grant_t;

  function automatic logic [2:0] grant_onehot(input grant_t g);
    logic [2:0] oh;
    oh = '0;
    case (g)
      GNT_CPU: oh[REQ_CPU] = 1'b1;
      GNT_VID: oh[REQ_VID] = 1'b1;
      GNT_AUD: oh[REQ_AUD] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/pgm_arb_prio.sv
// Combinational winner select: promoted audio, then CPU, video, audio.
// Requests arrive already masked, so this block holds no state.
module pgm_arb_prio
  import pgm_pkg::*;
(
  input  logic [2:0] req,
  input  logic       promote,
  output grant_t     winner
);

  always_comb begin
    winner = GNT_NONE;
    if (promote && req[REQ_AUD]) begin
      winner = GNT_AUD;
    end else if (req[REQ_CPU]) begin
      winner = GNT_CPU;
    end else if (req[REQ_VID]) begin
      winner = GNT_VID;
    end else if (req[REQ_AUD]) begin
      winner = GNT_AUD;
    end
  end

endmodule

// File: rtl/pgm_ddram_arbiter.sv
// Three-requester DDRAM read arbiter with a loader write pass-through mode,
// audio starvation aging and a WAIT watchdog that forces an all-ones completion.
module pgm_ddram_arbiter
  import pgm_pkg::*;
#(
  parameter int unsigned AGE_LIMIT = 64,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                fixed_50m_clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic [DDRAM_AW-1:0] cpu_addr,
  output logic                cpu_ack,
  input  logic                vid_req,
  input  logic [DDRAM_AW-1:0] vid_addr,
  output logic                vid_ack,
  input  logic                aud_req,
  input  logic [DDRAM_AW-1:0] aud_addr,
  output logic                aud_ack,
  output logic [DDRAM_DW-1:0] rd_data,
  input  logic                ld_en,
  input  logic                ld_wr,
  input  logic [DDRAM_AW-1:0] ld_addr,
  input  logic [DDRAM_DW-1:0] ld_din,
  input  logic [7:0]          ld_be,
  output logic                ld_busy,
  output logic                ddram_rd,
  output logic                ddram_we,
  output logic [DDRAM_AW-1:0] ddram_addr,
  output logic [DDRAM_DW-1:0] ddram_din,
  output logic [7:0]          ddram_be,
  input  logic [DDRAM_DW-1:0] ddram_dout,
  input  logic                ddram_busy,
  input  logic                ddram_dout_ready,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t                state_q, state_d;
  grant_t                grant_q, grant_d;
  logic [DDRAM_AW-1:0]   addr_q, addr_d;
  logic [DDRAM_DW-1:0]   rd_data_q, rd_data_d;
  logic [2:0]            ack_q, ack_d;
  logic [2:0]            mask_q, mask_d;
  logic                  done_q, done_d;
  logic [TW-1:0]         wcnt_q, wcnt_d;
  logic                  terr_q, terr_d;
  logic [7:0]            age_q, age_d;

  logic [2:0]            req_masked;
  logic                  promote;
  grant_t                winner;
  logic [DDRAM_AW-1:0]   winner_addr;

  // The requester acked this cycle still holds req high, so keep it out of the race.
  assign req_masked = {aud_req, vid_req, cpu_req} & ~mask_q;
  assign promote    = (32'(age_q) >= AGE_LIMIT);

  pgm_arb_prio u_prio (
    .req     (req_masked),
    .promote (promote),
    .winner  (winner)
  );

  always_comb begin
    winner_addr = cpu_addr;
    case (winner)
      GNT_VID: winner_addr = vid_addr;
      GNT_AUD: winner_addr = aud_addr;
      default: winner_addr = cpu_addr;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    ack_d     = '0;
    mask_d    = '0;
    done_d    = done_q;
    wcnt_d    = wcnt_q;
    terr_d    = terr_q;
    age_d     = age_q;

    if (grant_q == GNT_AUD) begin
      age_d = '0;
    end else if (aud_req && (age_q != 8'hFF)) begin
      age_d = age_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ld_en) begin
          state_d = ST_LOAD;
        end else if (winner != GNT_NONE) begin
          grant_d = winner;
          addr_d  = winner_addr;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!ddram_busy) begin
          state_d = ST_WAIT;
          wcnt_d  = '0;
          done_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        // Data is captured first; the ack follows one cycle later.
        if (done_q) begin
          ack_d   = grant_onehot(grant_q);
          mask_d  = grant_onehot(grant_q);
          grant_d = GNT_NONE;
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (ddram_dout_ready) begin
          rd_data_d = ddram_dout;
          done_d    = 1'b1;
        end else if (wcnt_q == TMO_LAST) begin
          rd_data_d = '1;
          ack_d     = grant_onehot(grant_q);
          mask_d    = grant_onehot(grant_q);
          grant_d   = GNT_NONE;
          terr_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end
      ST_LOAD: begin
        if (!ld_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fixed_50m_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= GNT_NONE;
      addr_q    <= '0;
      rd_data_q <= '0;
      ack_q     <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      wcnt_q    <= '0;
      terr_q    <= 1'b0;
      age_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      wcnt_q    <= wcnt_d;
      terr_q    <= terr_d;
      age_q     <= age_d;
    end
  end

  assign cpu_ack     = ack_q[REQ_CPU];
  assign vid_ack     = ack_q[REQ_VID];
  assign aud_ack     = ack_q[REQ_AUD];
  assign rd_data     = rd_data_q;
  assign grant       = grant_q;
  assign timeout_err = terr_q;

  // DDRAM strobes must react to busy in the same cycle, so they stay combinational.
  assign ddram_rd   = (state_q == ST_ISSUE) && !ddram_busy;
  assign ddram_we   = (state_q == ST_LOAD) && ld_wr;
  assign ddram_addr = (state_q == ST_LOAD) ? ld_addr : addr_q;
  assign ddram_din  = (state_q == ST_LOAD) ? ld_din : '0;
  assign ddram_be   = (state_q == ST_LOAD) ? ld_be : 8'hFF;
  assign ld_busy    = (state_q == ST_LOAD) ? ddram_busy : ld_en;

endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// Directed bench for pgm_ddram_arbiter with a small DDRAM read-latency model;
// the model returns {32'hA5A5_0000, 3'b0, addr} for every read.
module tb_pgm_ddram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, vid_req, aud_req;
  logic [28:0] cpu_addr, vid_addr, aud_addr;
  logic        cpu_ack, vid_ack, aud_ack;
  logic [63:0] rd_data;
  logic        ld_en, ld_wr;
  logic [28:0] ld_addr;
  logic [63:0] ld_din;
  logic [7:0]  ld_be;
  logic        ld_busy;
  logic        ddram_rd, ddram_we;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic [63:0] ddram_dout;
  logic        ddram_busy, ddram_dout_ready;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  int          model_lat = 5;
  bit          model_en  = 1'b1;
  int          pend_cnt  = 0;
  logic [28:0] pend_addr = '0;

  pgm_ddram_arbiter #(.AGE_LIMIT(64), .TIMEOUT(1024)) dut (
    .fixed_50m_clk    (clk),
    .reset            (reset),
    .cpu_req          (cpu_req),
    .cpu_addr         (cpu_addr),
    .cpu_ack          (cpu_ack),
    .vid_req          (vid_req),
    .vid_addr         (vid_addr),
    .vid_ack          (vid_ack),
    .aud_req          (aud_req),
    .aud_addr         (aud_addr),
    .aud_ack          (aud_ack),
    .rd_data          (rd_data),
    .ld_en            (ld_en),
    .ld_wr            (ld_wr),
    .ld_addr          (ld_addr),
    .ld_din           (ld_din),
    .ld_be            (ld_be),
    .ld_busy          (ld_busy),
    .ddram_rd         (ddram_rd),
    .ddram_we         (ddram_we),
    .ddram_addr       (ddram_addr),
    .ddram_din        (ddram_din),
    .ddram_be         (ddram_be),
    .ddram_dout       (ddram_dout),
    .ddram_busy       (ddram_busy),
    .ddram_dout_ready (ddram_dout_ready),
    .grant            (grant),
    .timeout_err      (timeout_err)
  );

  initial forever #10 clk = ~clk;

  // dout_ready pulses model_lat cycles after the cycle carrying ddram_rd.
  always @(negedge clk) begin
    ddram_dout_ready = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        ddram_dout_ready = 1'b1;
        ddram_dout       = {32'hA5A5_0000, 3'b000, pend_addr};
      end
    end
    if (model_en && ddram_rd) begin
      pend_cnt  = model_lat;
      pend_addr = ddram_addr;
    end
  end

  task automatic wait_ack(input int sel, input int limit, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if ((sel == 0 && cpu_ack) || (sel == 1 && vid_ack) || (sel == 2 && aud_ack)) return;
      cyc++;
      if (cyc > limit) begin
        cyc = -1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant); end
    n_checks++; if ({cpu_ack, vid_ack, aud_ack} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b expected 000", {cpu_ack, vid_ack, aud_ack}); end
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    n_checks++; if ({ddram_rd, ddram_we} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00", {ddram_rd, ddram_we}); end
    n_checks++; if (ld_busy !== 1'b0) begin n_fail++; $display("FAIL reset_ld_busy: got %b expected 0", ld_busy); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    n_checks++; if (ddram_be !== 8'hFF) begin n_fail++; $display("FAIL reset_be: got %h expected ff", ddram_be); end
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_single_cpu();
    int rd_cyc = -1, ack_cyc = -1;
    logic [28:0] rd_addr = '0;
    logic [1:0]  rd_grant = '0;
    logic [63:0] got = '0;
    @(posedge clk); #1;
    model_lat = 5;
    cpu_addr  = 29'h0000123;
    cpu_req   = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ddram_rd) begin rd_cyc = k; rd_addr = ddram_addr; rd_grant = grant; end
      if (cpu_ack) begin ack_cyc = k; got = rd_data; break; end
    end
    cpu_req = 1'b0;
    $display("single_cpu: rd at %0d addr %h, ack at %0d data %h", rd_cyc, rd_addr, ack_cyc, got);
    n_checks++; if (rd_cyc !== 1) begin n_fail++; $display("FAIL single_rd_cycle: got %0d expected 1", rd_cyc); end
    n_checks++; if (rd_addr !== 29'h0000123) begin n_fail++; $display("FAIL single_rd_addr: got %h expected 0000123", rd_addr); end
    n_checks++; if (rd_grant !== 2'd1) begin n_fail++; $display("FAIL single_grant: got %0d expected 1", rd_grant); end
    n_checks++; if (ack_cyc !== 8) begin n_fail++; $display("FAIL single_latency: got %0d expected 8", ack_cyc); end
    n_checks++; if (got !== 64'hA5A5_0000_0000_0123) begin n_fail++; $display("FAIL single_data: got %h expected a5a5000000000123", got); end
    n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL single_grant_clear: got %0d expected 0", grant); end
    @(negedge clk);
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b expected 0", cpu_ack); end
  endtask

  task automatic test_issue_busy();
    int bad = 0;
    int cyc;
    @(posedge clk); #1;
    model_lat  = 3;
    ddram_busy = 1'b1;
    vid_addr   = 29'h0000456;
    vid_req    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ddram_rd !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL busy_hold_rd: got %0d strobes expected 0", bad); end
    n_checks++; if (grant !== 2'd2) begin n_fail++; $display("FAIL busy_grant: got %0d expected 2", grant); end
    @(posedge clk); #1;
    ddram_busy = 1'b0;
    @(negedge clk);
    n_checks++; if (ddram_rd !== 1'b1 || ddram_addr !== 29'h0000456) begin n_fail++; $display("FAIL busy_release_rd: got rd %b addr %h expected 1 0000456", ddram_rd, ddram_addr); end
    wait_ack(1, 20, cyc);
    vid_req = 1'b0;
    $display("issue_busy: vid ack after %0d cycles data %h", cyc, rd_data);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL busy_ack_cycle: got %0d expected 4", cyc); end
    n_checks++; if (rd_data !== 64'hA5A5_0000_0000_0456) begin n_fail++; $display("FAIL busy_data: got %h expected a5a5000000000456", rd_data); end
  endtask

  task automatic test_same_cycle_priority();
    int order[3] = '{0, 0, 0};
    logic [63:0] dat[3];
    int n = 0, cc = 0, vc = 0, ac = 0;
    @(posedge clk); #1;
    model_lat = 2;
    cpu_addr = 29'h0000100; vid_addr = 29'h0000200; aud_addr = 29'h0000300;
    cpu_req = 1'b1; vid_req = 1'b1; aud_req = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (cpu_ack) begin cc++; if (n < 3) begin order[n] = 1; dat[n] = rd_data; n++; end cpu_req = 1'b0; end
      if (vid_ack) begin vc++; if (n < 3) begin order[n] = 2; dat[n] = rd_data; n++; end vid_req = 1'b0; end
      if (aud_ack) begin ac++; if (n < 3) begin order[n] = 3; dat[n] = rd_data; n++; end aud_req = 1'b0; end
    end
    $display("priority: order %0d %0d %0d, acks cpu %0d vid %0d aud %0d", order[0], order[1], order[2], cc, vc, ac);
    n_checks++; if (order[0] !== 1 || order[1] !== 2 || order[2] !== 3) begin n_fail++; $display("FAIL prio_order: got %0d%0d%0d expected 123", order[0], order[1], order[2]); end
    n_checks++; if (cc !== 1 || vc !== 1 || ac !== 1) begin n_fail++; $display("FAIL prio_ack_count: got %0d %0d %0d expected 1 1 1", cc, vc, ac); end
    n_checks++; if (dat[0] !== 64'hA5A5_0000_0000_0100) begin n_fail++; $display("FAIL prio_data0: got %h expected a5a5000000000100", dat[0]); end
    n_checks++; if (dat[1] !== 64'hA5A5_0000_0000_0200) begin n_fail++; $display("FAIL prio_data1: got %h expected a5a5000000000200", dat[1]); end
    n_checks++; if (dat[2] !== 64'hA5A5_0000_0000_0300) begin n_fail++; $display("FAIL prio_data2: got %h expected a5a5000000000300", dat[2]); end
  endtask

  task automatic test_audio_aging();
    int cc = 0, vc = 0, aud_cyc = -1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_lat = 2;
    cpu_req = 1'b1; vid_req = 1'b1; aud_req = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (cpu_ack) cc++;
      if (vid_ack) vc++;
      if (aud_ack) begin aud_cyc = k; break; end
    end
    cpu_req = 1'b0; vid_req = 1'b0; aud_req = 1'b0;
    $display("aging: audio ack at cycle %0d after cpu %0d vid %0d", aud_cyc, cc, vc);
    n_checks++; if (aud_cyc < 64 || aud_cyc > 74) begin n_fail++; $display("FAIL aging_window: got %0d expected 64..74", aud_cyc); end
    n_checks++; if (cc !== 7 || vc !== 6) begin n_fail++; $display("FAIL aging_alternation: got cpu %0d vid %0d expected 7 6", cc, vc); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    @(posedge clk); #1;
    model_en = 1'b0;
    cpu_addr = 29'h0000777;
    cpu_req  = 1'b1;
    wait_ack(0, 1100, cyc);
    cpu_req = 1'b0;
    $display("timeout: cpu ack at cycle %0d data %h err %b", cyc, rd_data, timeout_err);
    n_checks++; if (cyc !== 1026) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected 1026", cyc); end
    n_checks++; if (rd_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL timeout_data: got %h expected all ones", rd_data); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b expected 1", timeout_err); end
    @(posedge clk); #1;
    model_en  = 1'b1;
    model_lat = 3;
    cpu_addr  = 29'h0000778;
    cpu_req   = 1'b1;
    wait_ack(0, 30, cyc);
    cpu_req = 1'b0;
    $display("timeout: follow-up ack at cycle %0d data %h", cyc, rd_data);
    n_checks++; if (rd_data !== 64'hA5A5_0000_0000_0778) begin n_fail++; $display("FAIL timeout_followup_data: got %h expected a5a5000000000778", rd_data); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b expected 1", timeout_err); end
  endtask

  task automatic test_load_mid_wait();
    int cyc;
    int bad = 0;
    @(posedge clk); #1;
    model_lat = 4;
    cpu_addr  = 29'h0000ABC;
    cpu_req   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ddram_rd) break;
    end
    @(posedge clk); #1;
    ld_en = 1'b1;
    @(negedge clk);
    n_checks++; if (ld_busy !== 1'b1) begin n_fail++; $display("FAIL load_busy_in_wait: got %b expected 1", ld_busy); end
    wait_ack(0, 30, cyc);
    cpu_req = 1'b0;
    $display("load: cpu ack after %0d cycles data %h", cyc, rd_data);
    n_checks++; if (rd_data !== 64'hA5A5_0000_0000_0ABC) begin n_fail++; $display("FAIL load_read_data: got %h expected a5a5000000000abc", rd_data); end
    n_checks++; if (ld_busy !== 1'b1) begin n_fail++; $display("FAIL load_busy_before_load: got %b expected 1", ld_busy); end
    @(posedge clk); #1;
    ld_wr = 1'b1; ld_addr = 29'h0001000; ld_din = 64'h0123_4567_89AB_CDEF; ld_be = 8'h0C;
    vid_addr = 29'h0000DEF; vid_req = 1'b1;
    @(negedge clk);
    $display("load: write we %b addr %h din %h be %h", ddram_we, ddram_addr, ddram_din, ddram_be);
    n_checks++; if (ddram_we !== 1'b1 || ddram_be !== 8'h0C) begin n_fail++; $display("FAIL load_we_be: got %b %h expected 1 0c", ddram_we, ddram_be); end
    n_checks++; if (ddram_addr !== 29'h0001000 || ddram_din !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL load_addr_din: got %h %h", ddram_addr, ddram_din); end
    n_checks++; if (ld_busy !== 1'b0 || ddram_rd !== 1'b0) begin n_fail++; $display("FAIL load_busy_rd: got %b %b expected 0 0", ld_busy, ddram_rd); end
    @(posedge clk); #1;
    ddram_busy = 1'b1; ld_wr = 1'b0;
    @(negedge clk);
    n_checks++; if (ld_busy !== 1'b1 || ddram_we !== 1'b0) begin n_fail++; $display("FAIL load_busy_follow: got %b %b expected 1 0", ld_busy, ddram_we); end
    @(posedge clk); #1;
    ddram_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (vid_ack || ddram_rd) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL load_pending: got %0d service events expected 0", bad); end
    @(posedge clk); #1;
    ld_en = 1'b0;
    @(negedge clk);
    n_checks++; if (ddram_be !== 8'h0C) begin n_fail++; $display("FAIL load_exit_delay: got be %h expected 0c", ddram_be); end
    wait_ack(1, 30, cyc);
    vid_req = 1'b0;
    ld_be = 8'h00;
    $display("load: pending vid ack after %0d cycles data %h", cyc, rd_data);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL load_vid_cycle: got %0d expected 7", cyc); end
    n_checks++; if (rd_data !== 64'hA5A5_0000_0000_0DEF) begin n_fail++; $display("FAIL load_vid_data: got %h expected a5a5000000000def", rd_data); end
  endtask

  task automatic test_reset_mid_wait();
    int acks = 0, grants = 0, rds = 0;
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL rst_pre_err: got %b expected 1", timeout_err); end
    @(posedge clk); #1;
    model_lat = 6;
    aud_addr  = 29'h0000321;
    aud_req   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ddram_rd) break;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; aud_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cpu_ack || vid_ack || aud_ack) acks++;
      if (grant !== 2'd0) grants++;
      if (ddram_rd) rds++;
    end
    $display("reset_mid_wait: acks %0d grants %0d rds %0d rd_data %h err %b", acks, grants, rds, rd_data, timeout_err);
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL rst_no_ack: got %0d expected 0", acks); end
    n_checks++; if (grants !== 0 || rds !== 0) begin n_fail++; $display("FAIL rst_idle: got grants %0d rds %0d expected 0 0", grants, rds); end
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL rst_late_ready: got %h expected 0", rd_data); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_err_clear: got %b expected 0", timeout_err); end
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; vid_req = 1'b0; aud_req = 1'b0;
    cpu_addr = '0; vid_addr = '0; aud_addr = '0;
    ld_en = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_din = '0; ld_be = '0;
    ddram_busy = 1'b0; ddram_dout_ready = 1'b0; ddram_dout = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_single_cpu();
    repeat (3) @(posedge clk);
    test_issue_busy();
    repeat (3) @(posedge clk);
    test_same_cycle_priority();
    test_audio_aging();
    test_timeout();
    repeat (3) @(posedge clk);
    test_load_mid_wait();
    repeat (3) @(posedge clk);
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
